imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory the single-cycle core later fetches from. It accepts a framed byte stream (start PC, word count, little-endian instructions, optional checksum) over a valid/ready handshake. It emits one instruction-memory write per assembled word, then publishes `startpc` and raises `cpu_run`, which releases the core from reset.

## Interface
- `MAX_WORDS`, 1024: largest accepted word count; larger counts are a frame error.
- `CLK` input 1: clock; all state updates on the rising edge.
- `resetl` input 1: reset, synchronous, active-high.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader can accept a byte.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_addr` output 64: byte address of the word being written.
- `imem_wdata` output 32: instruction word being written.
- `startpc` output 64: start PC taken from the frame header.
- `cpu_run` output 1: high once the load completes; drives the core's run/reset input.
- `done` output 1: load finished successfully.
- `error` output 1: frame rejected.

## Operation
- A byte is accepted on a rising edge with `in_valid && in_ready`. `in_ready` = 1 in `HDR_PC`, `HDR_CNT`, `DATA` and `CSUM`, and 0 in `DONE` and `ERR`.
- Frame layout:
  - 8 bytes start PC, LSB first.
  - 2 bytes word count N, LSB first.
  - N×4 bytes instructions, each LSB first.
  - 1 checksum byte, only when checksum is enabled.
- FSM transitions:
  - `HDR_PC`: after the 8th byte, go to `ERR` if `pc[1:0] != 0`; otherwise go to `HDR_CNT`.
  - `HDR_CNT`: after the 2nd byte, go to `ERR` if `N > MAX_WORDS`. If N == 0, go to `CSUM` (or `DONE` when checksum is disabled). Otherwise go to `DATA`.
  - `DATA`: every 4th byte completes word k, which is written to `startpc + 4*k`. After word N-1, go to `CSUM` (or `DONE`).
  - `CSUM`: compare the received byte against the running checksum. Match goes to `DONE`; mismatch goes to `ERR`.
  - `DONE` and `ERR` are terminal; only `resetl` leaves them.
- Byte counter: 2 bits within a word. Word counter: 16 bits. Address arithmetic is 64-bit modulo 2^64; wrap past 2^64-1 is not checked.
- The running checksum is the 8-bit XOR of every accepted byte from the first header byte through the last data byte.
- `startpc` holds 0 until header byte 8 is accepted, then holds the received value until reset.
- `cpu_run` = `done` = (state == `DONE`). `error` = (state == `ERR`). `cpu_run` never asserts after an error.
- Reset values: state `HDR_PC`, all counters 0, checksum 0. Outputs reset to `in_ready` 1, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `startpc` 0, `cpu_run` 0, `done` 0, `error` 0.
- `resetl` asserted mid-frame discards all progress on that edge. Words already written to instruction memory are not erased.
- Gaps (`in_valid` low) may occur anywhere in the frame; they do not change state.

## Timing
- `imem_we`, `imem_addr` and `imem_wdata` are registered. The strobe is high exactly in the cycle after the 4th byte of a word is accepted.
- Minimum spacing between strobes is 4 cycles, since the loader accepts at most one byte per cycle.
- `done` and `cpu_run` rise in the cycle after the accepting edge of the final frame byte. That byte is the checksum byte, or the last data byte when checksum is disabled.
- When the last data byte (checksum disabled) triggers both a write and `DONE`, `imem_we` and `cpu_run` rise in the same cycle. The write completes on that cycle's edge, before the core's first negedge PC load.
- `error` rises in the cycle after the offending byte is accepted. `in_ready` drops in that same cycle.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: the `CSUM` state and XOR accumulator exist, and a trailing checksum byte is required.
- `IMEM_LOADER_CHECKSUM_EN` undefined: no checksum logic. The frame ends after the last data byte, or after the count header when N == 0. The only errors are misalignment and oversize count.

## Structure
- `imem_loader_pkg`:
  - state enum `HDR_PC`, `HDR_CNT`, `DATA`, `CSUM`, `DONE`, `ERR`.
  - constants `PC_HDR_BYTES = 8`, `CNT_HDR_BYTES = 2`, `WORD_BYTES = 4`.
- Sub-module `loader_byte_asm`: a little-endian shift assembler with clear, load-byte and byte-index inputs. It is reused for the 64-bit PC, the 16-bit count and the 32-bit words through a width parameter.

## Test plan
- PC `0x0000000000000100`, N = 2, words `0xF84003E9`, `0x8B0A0128`, correct checksum:
  - writes at `0x100` and `0x104` with those data values.
  - `cpu_run` = 1, `startpc` = `0x100`.
- Same frame with `in_valid` toggled every other cycle: identical writes. Strobes are at least 8 cycles apart.
- PC `0x102`: `error` = 1 after the 8th byte, `in_ready` = 0, and no `imem_we` ever asserts.
- N = 1025 with `MAX_WORDS` = 1024: `error` = 1 after the 2nd count byte.
- Correct frame with the checksum byte XOR `0x01` (checksum enabled): writes occur, `error` = 1, `cpu_run` stays 0.
- Reset asserted after 5 data bytes, then a fresh N = 0 frame from PC `0x40`: `done` = 1 and `startpc` = `0x40`, with no writes after the reset.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared definitions for the boot-time instruction loader.
//
// Contents:
//   state_t        : 3-bit loader state encoding (HDR_PC, HDR_CNT, DATA,
//                    CSUM, DONE, ERR), kept as plain constants so the
//                    encoding stays visible and matches legacy state decodes.
//   PC_HDR_BYTES   : bytes in the start-PC header field.
//   CNT_HDR_BYTES  : bytes in the word-count header field.
//   WORD_BYTES     : bytes per instruction word.
package imem_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t HDR_PC  = 3'd0;
  localparam state_t HDR_CNT = 3'd1;
  localparam state_t DATA    = 3'd2;
  localparam state_t CSUM    = 3'd3;
  localparam state_t DONE    = 3'd4;
  localparam state_t ERR     = 3'd5;

  localparam int unsigned PC_HDR_BYTES  = 8;
  localparam int unsigned CNT_HDR_BYTES = 2;
  localparam int unsigned WORD_BYTES    = 4;

endpackage

// File: rtl/imem_loader_byte_asm.sv
// loader_byte_asm -- little-endian byte assembler.
//
// Collects bytes into a WIDTH-bit field; byte_idx selects the lane written
// by in_byte when load is high (lane 0 = least significant byte).
//
// Ports:
//   CLK       in   clock
//   clear     in   synchronous clear of the stored field (active-high)
//   load      in   write in_byte into lane byte_idx on this edge
//   byte_idx  in   target byte lane
//   in_byte   in   byte to store
//   value     out  stored field with the current byte already merged in,
//                  so the completed field is usable on the edge that
//                  accepts its final byte
module loader_byte_asm #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                             CLK,
  input  logic                             clear,
  input  logic                             load,
  input  logic [$clog2(WIDTH/8)-1:0]       byte_idx,
  input  logic [7:0]                       in_byte,
  output logic [WIDTH-1:0]                 value
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(NBYTES);

  logic [WIDTH-1:0] stored;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    value = stored;
    for (int i = 0; i < NBYTES; i++) begin
      if (load && byte_idx == IDX_W'(i)) value[i*8 +: 8] = in_byte;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK) begin
    if (clear) stored <= '0;
    else       stored <= value;
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- boot-time program loader for the instruction memory.
//
// Consumes a framed byte stream over a valid/ready handshake:
//   8 bytes start PC (LSB first), 2 bytes word count N (LSB first),
//   N x 4 bytes instructions (LSB first), then one XOR checksum byte when
//   IMEM_LOADER_CHECKSUM_EN is defined. Each completed word produces one
//   registered instruction-memory write at startpc + 4*k; a clean frame
//   ends in DONE, which raises cpu_run to release the core.
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  defined   -> trailing checksum byte required
//                            undefined -> no checksum logic
//
// Ports:
//   CLK         in   clock, rising edge
//   resetl      in   synchronous active-high reset
//   in_data     in   stream byte
//   in_valid    in   in_data valid
//   in_ready    out  loader can accept a byte
//   imem_we     out  one-cycle instruction-memory write strobe
//   imem_addr   out  byte address of the word being written
//   imem_wdata  out  instruction word being written
//   startpc     out  start PC from the frame header (0 until received)
//   cpu_run     out  load complete; drives the core's run input
//   done        out  load finished successfully
//   error       out  frame rejected
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [63:0] startpc,
  output logic        cpu_run,
  output logic        done,
  output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FRAME_END = CSUM;
`else
  localparam state_t FRAME_END = DONE;
`endif

  state_t      state, state_nxt;
  logic        accept;
  logic [2:0]  hdr_cnt;
  logic [1:0]  byte_cnt;
  logic [15:0] word_cnt;
  logic [63:0] wr_addr;
  logic [63:0] pc_val;
  logic [15:0] cnt_val;
  logic [31:0] word_val;
  logic        last_pc_byte, last_cnt_byte, last_word_byte, last_word;

  assign in_ready = (state == HDR_PC) || (state == HDR_CNT) ||
                    (state == DATA)   || (state == CSUM);
  assign accept   = in_valid && in_ready;
  assign done     = (state == DONE);
  assign cpu_run  = (state == DONE);
  assign error    = (state == ERR);

  assign last_pc_byte   = (hdr_cnt == 3'(PC_HDR_BYTES - 1));
  assign last_cnt_byte  = (hdr_cnt == 3'(CNT_HDR_BYTES - 1));
  assign last_word_byte = (byte_cnt == 2'(WORD_BYTES - 1));
  // Only evaluated in DATA, where the count is at least 1.
  assign last_word      = (word_cnt == cnt_val - 16'd1);

  loader_byte_asm #(.WIDTH(64)) u_pc_asm (
    .CLK      (CLK),
    .clear    (resetl),
    .load     (accept && state == HDR_PC),
    .byte_idx (hdr_cnt),
    .in_byte  (in_data),
    .value    (pc_val)
  );

  loader_byte_asm #(.WIDTH(16)) u_cnt_asm (
    .CLK      (CLK),
    .clear    (resetl),
    .load     (accept && state == HDR_CNT),
    .byte_idx (hdr_cnt[0]),
    .in_byte  (in_data),
    .value    (cnt_val)
  );

  loader_byte_asm #(.WIDTH(32)) u_word_asm (
    .CLK      (CLK),
    .clear    (resetl),
    .load     (accept && state == DATA),
    .byte_idx (byte_cnt),
    .in_byte  (in_data),
    .value    (word_val)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Covers header and data bytes; the checksum byte itself is excluded.
  always_ff @(posedge CLK) begin
    if (resetl) csum <= 8'h00;
    else if (accept && (state == HDR_PC || state == HDR_CNT || state == DATA))
      csum <= csum ^ in_data;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      HDR_PC: begin
        if (accept && last_pc_byte)
          state_nxt = (pc_val[1:0] != 2'b00) ? ERR : HDR_CNT;
      end
      HDR_CNT: begin
        if (accept && last_cnt_byte) begin
          if (32'(cnt_val) > MAX_WORDS) state_nxt = ERR;
          else if (cnt_val == 16'd0)    state_nxt = FRAME_END;
          else                          state_nxt = DATA;
        end
      end
      DATA: begin
        if (accept && last_word_byte && last_word) state_nxt = FRAME_END;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_nxt = (in_data == csum) ? DONE : ERR;
      end
`endif
      default: state_nxt = state;
    endcase
  end

  // Reset clears progress only; words already written stay in memory.
  always_ff @(posedge CLK) begin
    if (resetl) begin
      state      <= HDR_PC;
      hdr_cnt    <= 3'd0;
      byte_cnt   <= 2'd0;
      word_cnt   <= 16'd0;
      wr_addr    <= 64'd0;
      startpc    <= 64'd0;
      imem_we    <= 1'b0;
      imem_addr  <= 64'd0;
      imem_wdata <= 32'd0;
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          HDR_PC: begin
            if (last_pc_byte) begin
              hdr_cnt <= 3'd0;
              startpc <= pc_val;
              wr_addr <= pc_val;
            end else begin
              hdr_cnt <= hdr_cnt + 3'd1;
            end
          end
          HDR_CNT: begin
            hdr_cnt <= last_cnt_byte ? 3'd0 : hdr_cnt + 3'd1;
          end
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            if (last_word_byte) begin
              imem_we    <= 1'b1;
              imem_addr  <= wr_addr;
              imem_wdata <= word_val;
              wr_addr    <= wr_addr + 64'd4;
              word_cnt   <= word_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- directed self-checking bench for imem_loader.
// Works with IMEM_LOADER_CHECKSUM_EN defined or undefined; checksum-only
// steps are compiled in only when the option is enabled.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        resetl = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, imem_we, cpu_run, done, error;
  logic [63:0] imem_addr, startpc;
  logic [31:0] imem_wdata;

  int n_checks = 0;
  int n_fails  = 0;

  imem_loader #(.MAX_WORDS(1024)) dut (
    .CLK        (CLK),
    .resetl     (resetl),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .startpc    (startpc),
    .cpu_run    (cpu_run),
    .done       (done),
    .error      (error)
  );

  always #5 CLK = ~CLK;

  // Write log, sampled on the falling edge, away from the active edge.
  int          cyc = 0;
  int          n_wr = 0;
  logic [63:0] log_addr [0:31];
  logic [31:0] log_data [0:31];
  int          log_cyc  [0:31];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (imem_we && n_wr < 32) begin
      log_addr[n_wr] = imem_addr;
      log_data[n_wr] = imem_wdata;
      log_cyc[n_wr]  = cyc;
      n_wr = n_wr + 1;
    end
  end

  logic [31:0] wbuf [0:3];
  logic [7:0]  fq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetl   = 1'b1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    resetl = 1'b0;
  endtask

  // Builds a frame into fq: header, nw words from wbuf, and (when the
  // checksum option is on) the XOR of all prior bytes, flipped by flip.
  task automatic build_frame(input logic [63:0] pc, input logic [15:0] n,
                             input int nw, input logic [7:0] flip);
    logic [7:0] x;
    fq.delete();
    for (int i = 0; i < 8; i++) fq.push_back(pc[i*8 +: 8]);
    fq.push_back(n[7:0]);
    fq.push_back(n[15:8]);
    for (int w = 0; w < nw; w++)
      for (int b = 0; b < 4; b++) fq.push_back(wbuf[w][b*8 +: 8]);
    x = 8'h00;
    foreach (fq[i]) x = x ^ fq[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    fq.push_back(x ^ flip);
`else
    if (flip != 8'h00) x = 8'h00;
`endif
  endtask

  // Sends bytes [first, last] of fq, one per cycle, with an idle cycle
  // after each byte when gap is set.
  task automatic send_range(input int first, input int last, input bit gap);
    for (int i = first; i <= last; i++) begin
      in_data  = fq[i];
      in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      if (gap) begin
        in_data = 8'hA5;
        @(posedge CLK); #1;
      end
    end
  endtask

  int base;

  initial begin
    wbuf[0] = 32'hF84003E9;
    wbuf[1] = 32'h8B0A0128;
    wbuf[2] = 32'h00000000;
    wbuf[3] = 32'h00000000;

    // Reset state.
    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_imem_we",  64'(imem_we), 64'd0);
    check("rst_addr",     imem_addr, 64'd0);
    check("rst_wdata",    64'(imem_wdata), 64'd0);
    check("rst_startpc",  startpc, 64'd0);
    check("rst_flags",    {61'd0, cpu_run, done, error}, 64'd0);

    // Back-to-back frame: PC 0x100, two words.
    base = n_wr;
    build_frame(64'h100, 16'd2, 2, 8'h00);
    send_range(0, 3, 1'b0);
    check("pc_partial_hidden", startpc, 64'd0);
    send_range(4, 7, 1'b0);
    check("pc_after_hdr", startpc, 64'h100);
    send_range(8, 17, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    // Last data byte: write strobe and run rise together.
    check("last_we_with_run", {62'd0, imem_we, cpu_run}, 64'd3);
`endif
    send_range(18, fq.size() - 1, 1'b0);
    check("run_after_frame", {61'd0, cpu_run, done, error}, 64'd6);
    check("ready_low_done", 64'(in_ready), 64'd0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("t1_nwrites", 64'(n_wr - base), 64'd2);
    check("t1_addr0", log_addr[base], 64'h100);
    check("t1_data0", 64'(log_data[base]), 64'hF84003E9);
    check("t1_addr1", log_addr[base+1], 64'h104);
    check("t1_data1", 64'(log_data[base+1]), 64'h8B0A0128);
    check("t1_spacing", 64'(log_cyc[base+1] - log_cyc[base]), 64'd4);
    check("t1_startpc", startpc, 64'h100);

    // Same frame with a gap after every byte.
    do_reset();
    base = n_wr;
    send_range(0, fq.size() - 1, 1'b1);
    @(posedge CLK); #1;
    check("t2_nwrites", 64'(n_wr - base), 64'd2);
    check("t2_addr0", log_addr[base], 64'h100);
    check("t2_data0", 64'(log_data[base]), 64'hF84003E9);
    check("t2_addr1", log_addr[base+1], 64'h104);
    check("t2_data1", 64'(log_data[base+1]), 64'h8B0A0128);
    check("t2_spacing", 64'(log_cyc[base+1] - log_cyc[base]), 64'd8);
    check("t2_run", {61'd0, cpu_run, done, error}, 64'd6);

    // Misaligned start PC.
    do_reset();
    base = n_wr;
    build_frame(64'h102, 16'd1, 1, 8'h00);
    send_range(0, 7, 1'b0);
    check("misalign_error", 64'(error), 64'd1);
    check("misalign_ready", 64'(in_ready), 64'd0);
    send_range(8, fq.size() - 1, 1'b0);
    @(posedge CLK); #1;
    check("misalign_nowrite", 64'(n_wr - base), 64'd0);
    check("misalign_flags", {61'd0, cpu_run, done, error}, 64'd1);

    // Largest legal count is accepted.
    do_reset();
    build_frame(64'h100, 16'd1024, 0, 8'h00);
    send_range(0, 9, 1'b0);
    check("n1024_state", {60'd0, in_ready, cpu_run, done, error}, 64'd8);

    // Oversize count.
    do_reset();
    build_frame(64'h100, 16'd1025, 0, 8'h00);
    send_range(0, 8, 1'b0);
    check("n1025_before_last", 64'(error), 64'd0);
    send_range(9, 9, 1'b0);
    check("n1025_error", {60'd0, in_ready, cpu_run, done, error}, 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Corrupted checksum: words land, but the frame is rejected.
    do_reset();
    base = n_wr;
    build_frame(64'h100, 16'd2, 2, 8'h01);
    send_range(0, fq.size() - 1, 1'b0);
    @(posedge CLK); #1;
    check("badsum_nwrites", 64'(n_wr - base), 64'd2);
    check("badsum_flags", {60'd0, in_ready, cpu_run, done, error}, 64'd1);
`endif

    // Reset mid-data, then an empty frame from PC 0x40.
    do_reset();
    build_frame(64'h100, 16'd2, 2, 8'h00);
    send_range(0, 14, 1'b0);
    do_reset();
    base = n_wr;
    check("midrst_startpc", startpc, 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);
    build_frame(64'h40, 16'd0, 0, 8'h00);
    send_range(0, fq.size() - 1, 1'b0);
    @(posedge CLK); #1;
    check("n0_flags", {61'd0, cpu_run, done, error}, 64'd6);
    check("n0_startpc", startpc, 64'h40);
    check("n0_nowrite", 64'(n_wr - base), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
